// File: rtl/spi_dac_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_dac_rx                                                       |
// | Brief   : Far-end receiver for the DAC serial link; deserializes nCS/SDI   |
// |           frames and splits them into command, data byte and zero pad.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_dac_rx #(
  parameter int CMD_W = 4,
  parameter int DW    = 8,
  parameter int PAD_W = 4
) (
  input  logic             ICLK,
  input  logic             nRST,
  input  logic             nCS,
  input  logic             SDI,
  output logic [DW-1:0]    DOUT,
  output logic [CMD_W-1:0] CFG,
  output logic             VALID,
  output logic             ERR,
  output logic             BUSY,
  output logic [7:0]       FCNT
);

  localparam int FL    = CMD_W + DW + PAD_W;
  localparam int CNT_W = $clog2(FL + 2);
  localparam logic [CNT_W-1:0] C_FL  = CNT_W'(FL);
  localparam logic [CNT_W-1:0] C_SAT = CNT_W'(FL + 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [FL-1:0]    sreg;
  logic [CNT_W-1:0] bitcnt;
  logic             ncs_d;
  logic             shift_en;
  logic             eof;
  logic             pad_ok;
  logic             good;

  // A frame already running when reset lifts must not be decoded, so the
  // receiver stays disarmed until it has seen the link idle at least once.
  always_ff @(posedge ICLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_DISARMED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    eof        = 1'b0;
    case (state)
      ST_DISARMED: begin
        if (nCS) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        shift_en = ~nCS;
        eof      = nCS & ~ncs_d;
      end
      default: begin
        state_next = ST_DISARMED;
      end
    endcase
  end

  generate
    if (PAD_W > 0) begin : g_pad_check
      assign pad_ok = (sreg[PAD_W-1:0] == '0);
    end else begin : g_no_pad
      assign pad_ok = 1'b1;
    end
  endgenerate

  assign good = (bitcnt == C_FL) && pad_ok;
  assign BUSY = (state == ST_ARMED) & ~nCS;

  // The bit counter saturates one past the frame length so that any overlong
  // frame, however long, can never alias back onto an exact-length count.
  always_ff @(posedge ICLK or negedge nRST) begin
    if (!nRST) begin
      sreg   <= '0;
      bitcnt <= '0;
      ncs_d  <= 1'b1;
      DOUT   <= '0;
      CFG    <= '0;
      FCNT   <= 8'd0;
      VALID  <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      ncs_d <= nCS;
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if (shift_en) begin
        sreg <= {sreg[FL-2:0], SDI};
        if (bitcnt != C_SAT) begin
          bitcnt <= bitcnt + C_ONE;
        end
      end else if (eof) begin
        bitcnt <= '0;
        if (good) begin
          DOUT  <= sreg[FL-CMD_W-1:PAD_W];
          CFG   <= sreg[FL-1:FL-CMD_W];
          FCNT  <= FCNT + 8'd1;
          VALID <= 1'b1;
        end else begin
          ERR <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spi_dac_rx                                                    |
// | Brief   : Directed self-checking bench for spi_dac_rx.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_dac_rx;

  logic       ICLK;
  logic       nRST;
  logic       nCS;
  logic       SDI;
  logic [7:0] DOUT;
  logic [3:0] CFG;
  logic       VALID;
  logic       ERR;
  logic       BUSY;
  logic [7:0] FCNT;

  int checks;
  int failures;

  spi_dac_rx #(.CMD_W(4), .DW(8), .PAD_W(4)) dut (
    .ICLK (ICLK),
    .nRST (nRST),
    .nCS  (nCS),
    .SDI  (SDI),
    .DOUT (DOUT),
    .CFG  (CFG),
    .VALID(VALID),
    .ERR  (ERR),
    .BUSY (BUSY),
    .FCNT (FCNT)
  );

  initial ICLK = 1'b0;
  always #5 ICLK = ~ICLK;

  // Link drives on the falling edge; value sent MSB first.
  task automatic drive_bits(input logic [31:0] value, input int n,
                            output logic busy_all, output logic busy_any);
    busy_all = 1'b1;
    busy_any = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge ICLK);
      nCS = 1'b0;
      SDI = value[i];
      #1;
      busy_all = busy_all & BUSY;
      busy_any = busy_any | BUSY;
    end
  endtask

  // Raises nCS and returns just after the end-of-frame rising edge.
  task automatic end_frame();
    @(negedge ICLK);
    nCS = 1'b1;
    SDI = 1'b1;
    @(posedge ICLK);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge ICLK);
    nCS = 1'b1;
    @(posedge ICLK);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge ICLK);
    nRST = 1'b0;
    nCS  = 1'b1;
    SDI  = 1'b0;
    @(negedge ICLK);
    nRST = 1'b1;
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    nCS  = 1'b1;
    SDI  = 1'b0;
    repeat (2) @(negedge ICLK);
    #1;
    checks++; if (DOUT !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h want 00", DOUT); end
    checks++; if (CFG !== 4'h0) begin failures++; $display("FAIL reset_cfg: got %h want 0", CFG); end
    checks++; if (VALID !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL reset_pulses: got valid=%b err=%b want 0 0", VALID, ERR); end
    checks++; if (FCNT !== 8'd0) begin failures++; $display("FAIL reset_fcnt: got %0d want 0", FCNT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    @(negedge ICLK);
    nRST = 1'b1;
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_good_frame();
    logic ba, bn;
    drive_bits(32'hF5A0, 16, ba, bn);
    checks++; if (ba !== 1'b1) begin failures++; $display("FAIL good_busy: got %b want 1 during frame", ba); end
    end_frame();
    checks++; if (VALID !== 1'b1) begin failures++; $display("FAIL good_valid: got %b want 1", VALID); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL good_err: got %b want 0", ERR); end
    checks++; if (DOUT !== 8'h5A) begin failures++; $display("FAIL good_dout: got %h want 5a", DOUT); end
    checks++; if (CFG !== 4'hF) begin failures++; $display("FAIL good_cfg: got %h want f", CFG); end
    checks++; if (FCNT !== 8'd1) begin failures++; $display("FAIL good_fcnt: got %0d want 1", FCNT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL good_busy_after: got %b want 0", BUSY); end
    idle_cycle();
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL good_valid_pulse: got %b want 0 one cycle later", VALID); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] frames [3];
    logic [7:0]  bytes  [3];
    logic ba, bn;
    int   vcount;
    frames[0] = 16'hF010; bytes[0] = 8'h01;
    frames[1] = 16'hFFF0; bytes[1] = 8'hFF;
    frames[2] = 16'h3800; bytes[2] = 8'h80;
    apply_reset();
    vcount = 0;
    for (int k = 0; k < 3; k++) begin
      drive_bits({16'h0, frames[k]}, 16, ba, bn);
      end_frame();
      if (VALID === 1'b1) vcount++;
      checks++; if (DOUT !== bytes[k]) begin failures++; $display("FAIL b2b_dout[%0d]: got %h want %h", k, DOUT, bytes[k]); end
      idle_cycle();
    end
    checks++; if (vcount !== 3) begin failures++; $display("FAIL b2b_valid_count: got %0d want 3", vcount); end
    checks++; if (CFG !== 4'h3) begin failures++; $display("FAIL b2b_cfg: got %h want 3", CFG); end
    checks++; if (FCNT !== 8'd3) begin failures++; $display("FAIL b2b_fcnt: got %0d want 3", FCNT); end
  endtask

  task automatic test_length_errors();
    logic ba, bn;
    // 15 bits then 17 bits, both carrying 0x77 in the data position.
    drive_bits(32'h7BB8, 15, ba, bn);
    end_frame();
    checks++; if (ERR !== 1'b1 || VALID !== 1'b0) begin failures++; $display("FAIL short_pulses: got err=%b valid=%b want 1 0", ERR, VALID); end
    checks++; if (DOUT !== 8'h80 || CFG !== 4'h3) begin failures++; $display("FAIL short_hold: got dout=%h cfg=%h want 80 3", DOUT, CFG); end
    idle_cycle();
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL short_err_pulse: got %b want 0 one cycle later", ERR); end
    drive_bits(32'h1EEE0, 17, ba, bn);
    end_frame();
    checks++; if (ERR !== 1'b1 || VALID !== 1'b0) begin failures++; $display("FAIL long_pulses: got err=%b valid=%b want 1 0", ERR, VALID); end
    checks++; if (DOUT !== 8'h80 || FCNT !== 8'd3) begin failures++; $display("FAIL long_hold: got dout=%h fcnt=%0d want 80 3", DOUT, FCNT); end
    idle_cycle();
    // 48-bit frame whose last 16 bits look valid; must still be rejected.
    drive_bits(32'hFFFF_FFFF, 32, ba, bn);
    drive_bits(32'h05A0, 16, ba, bn);
    end_frame();
    checks++; if (ERR !== 1'b1 || VALID !== 1'b0) begin failures++; $display("FAIL very_long_pulses: got err=%b valid=%b want 1 0", ERR, VALID); end
    checks++; if (DOUT !== 8'h80 || FCNT !== 8'd3) begin failures++; $display("FAIL very_long_hold: got dout=%h fcnt=%0d want 80 3", DOUT, FCNT); end
    idle_cycle();
  endtask

  task automatic test_bad_pad();
    logic ba, bn;
    drive_bits(32'hF5A1, 16, ba, bn);
    end_frame();
    checks++; if (ERR !== 1'b1 || VALID !== 1'b0) begin failures++; $display("FAIL pad_pulses: got err=%b valid=%b want 1 0", ERR, VALID); end
    checks++; if (DOUT !== 8'h80 || CFG !== 4'h3 || FCNT !== 8'd3) begin failures++; $display("FAIL pad_hold: got dout=%h cfg=%h fcnt=%0d want 80 3 3", DOUT, CFG, FCNT); end
    idle_cycle();
  endtask

  task automatic test_glitch();
    @(negedge ICLK);
    nCS = 1'b0;
    #2;
    nCS = 1'b1;
    @(posedge ICLK);
    #1;
    checks++; if (VALID !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL glitch_pulses: got valid=%b err=%b want 0 0", VALID, ERR); end
    idle_cycle();
    checks++; if (VALID !== 1'b0 || ERR !== 1'b0 || FCNT !== 8'd3) begin failures++; $display("FAIL glitch_after: got valid=%b err=%b fcnt=%0d want 0 0 3", VALID, ERR, FCNT); end
  endtask

  task automatic test_reset_mid_frame();
    logic ba, bn;
    drive_bits(32'hF1, 8, ba, bn);
    @(negedge ICLK);
    nRST = 1'b0;
    #1;
    checks++; if (DOUT !== 8'h00 || FCNT !== 8'd0 || BUSY !== 1'b0) begin failures++; $display("FAIL midrst_state: got dout=%h fcnt=%0d busy=%b want 00 0 0", DOUT, FCNT, BUSY); end
    @(negedge ICLK);
    nRST = 1'b1;
    drive_bits(32'h23, 8, ba, bn);
    checks++; if (bn !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0 while disarmed", bn); end
    end_frame();
    checks++; if (VALID !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL midrst_eof: got valid=%b err=%b want 0 0", VALID, ERR); end
    idle_cycle();
    checks++; if (VALID !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL midrst_after: got valid=%b err=%b want 0 0", VALID, ERR); end
    drive_bits(32'hF420, 16, ba, bn);
    end_frame();
    checks++; if (VALID !== 1'b1 || DOUT !== 8'h42) begin failures++; $display("FAIL midrst_next: got valid=%b dout=%h want 1 42", VALID, DOUT); end
    checks++; if (FCNT !== 8'd1) begin failures++; $display("FAIL midrst_fcnt: got %0d want 1", FCNT); end
    idle_cycle();
  endtask

  task automatic test_fcnt_wrap();
    logic ba, bn;
    logic [7:0] b;
    int missed;
    apply_reset();
    missed = 0;
    // One-cycle gaps between frames exercise the minimum inter-frame spacing.
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      drive_bits({16'h0, 4'h1, b, 4'h0}, 16, ba, bn);
      end_frame();
      if (VALID !== 1'b1) missed++;
    end
    checks++; if (missed !== 0) begin failures++; $display("FAIL wrap_missed: got %0d missing pulses want 0", missed); end
    checks++; if (FCNT !== 8'd0) begin failures++; $display("FAIL wrap_fcnt: got %0d want 0", FCNT); end
    checks++; if (DOUT !== 8'hFF) begin failures++; $display("FAIL wrap_dout: got %h want ff", DOUT); end
    drive_bits(32'h1AB0, 16, ba, bn);
    end_frame();
    checks++; if (FCNT !== 8'd1) begin failures++; $display("FAIL wrap_257: got %0d want 1", FCNT); end
    checks++; if (DOUT !== 8'hAB || CFG !== 4'h1) begin failures++; $display("FAIL wrap_257_data: got dout=%h cfg=%h want ab 1", DOUT, CFG); end
    idle_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_length_errors();
    test_bad_pad();
    test_glitch();
    test_reset_mid_frame();
    test_fcnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/spi_dac_rx.md
Name: spi_dac_rx

Overview:
- Receive-side model of the 16-bit DAC serial link: deserializes frames presented on nCS/SDI and decodes the command nibble, the data byte and the padding.
- Used as the far-end endpoint in the oscillator subsystem: loopback checking of the transmitter and an on-chip DAC shadow register.
- Runs on the same ICLK that paces the link. The link drives on the falling edge; this block samples on the rising edge.

Parameters:
CMD_W, 4, command/config field width (MSBs of frame)
DW, 8, data field width
PAD_W, 4, trailing pad width (must be all zeros)
(frame length FL = CMD_W+DW+PAD_W = 16 at defaults)

Ports:
ICLK  in  1  system/link clock; all state updates on rising edge
nRST  in  1  asynchronous active-low reset
nCS   in  1  frame select, active low
SDI   in  1  serial data, MSB first
DOUT  out DW  last accepted data byte (shadow register)
CFG   out CMD_W  last accepted command nibble
VALID out 1  one-cycle pulse: good frame accepted
ERR   out 1  one-cycle pulse: bad frame rejected
BUSY  out 1  high while a frame is being received (armed and nCS low)
FCNT  out 8  count of accepted frames, wraps 255->0

Behaviour:
- Reset (nRST low, async): sreg=0, bitcnt=0, armed=0, DOUT=0, CFG=0, VALID=0, ERR=0, FCNT=0, nCS_d=1.
- Arming: after reset, armed=0 until nCS is sampled high on a rising edge; then armed=1. A frame already in progress at reset release is ignored entirely, with no VALID and no ERR.
- nCS_d: registered copy of nCS, used for end-of-frame detection.
- Shift: on rising edge with armed=1 and nCS=0:
  - sreg <= {sreg[FL-2:0], SDI}
  - bitcnt <= bitcnt+1, saturating at FL+1 (5-bit counter)
- End of frame: rising edge with armed=1, nCS=1, nCS_d=0. Evaluate on that same edge:
  - good = (bitcnt==FL) and (sreg[PAD_W-1:0]==0)
  - good: DOUT <= sreg[FL-CMD_W-1:PAD_W]; CFG <= sreg[FL-1:FL-CMD_W]; FCNT <= FCNT+1; VALID=1 for exactly this one cycle.
  - bad (short frame, long frame or nonzero pad): DOUT, CFG and FCNT unchanged; ERR=1 for one cycle.
  - Both cases: bitcnt <= 0.
- VALID and ERR are registered, never both high, and default low on every other edge.
- Idle: nCS high with nCS_d high leaves all state unchanged, and bitcnt stays 0.
- Minimum gap: one cycle of nCS high between frames suffices. A frame may start on the edge right after the end-of-frame edge.
- Latency: VALID/DOUT update on the first rising edge at which nCS is sampled high, i.e. one cycle after the last data bit.
- BUSY = armed & ~nCS (combinational from registered armed).
- Glitch frame (nCS low for 0 sampled edges) produces no event.
- Reset mid-frame discards the partial frame. Re-arming requires nCS high as above.
- SDI is ignored whenever nCS is high.

Test Plan:
- Good frame: reset, nCS high 2 cycles, then frame 0xF5A0 MSB first over 16 cycles, then nCS high -> VALID pulse 1 cycle; DOUT=0x5A, CFG=0xF, FCNT=1, ERR=0.
- Back-to-back: frames 0xF010, 0xFFF0, 0x3800 with 2-cycle gaps -> three VALID pulses; final DOUT=0x80, CFG=0x3, FCNT=3.
- Length errors: 15-bit frame, then 17-bit frame, each carrying byte 0x77 -> ERR pulse each, no VALID; DOUT/CFG keep the prior value, FCNT unchanged.
- Bad pad: frame 0xF5A1 -> ERR pulse; DOUT unchanged.
- Reset mid-frame: assert nRST low after 8 bits of 0xF123 while nCS stays low, release with nCS still low for 8 more bits -> no VALID/ERR for that frame; the next full frame 0xF420 gives DOUT=0x42.
- FCNT wrap: 256 good frames -> FCNT returns to 0; the 257th frame gives FCNT=1.
